// File: rtl/control_unit.sv
// Instruction sequencer for the accumulator datapath: fetches 20-bit words from a
// synchronous program ROM and issues one-cycle control strobes in EXEC.
module control_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [19:0]       prog_data,
  output logic [15:0]       arg,
  input  logic              is_zero,
  output logic              ctl_arg,
  output logic              ctl_nad,
  output logic              ctl_shl,
  output logic              ctl_shr,
  output logic              ctl_read,
  output logic              ctl_write,
  output logic              ctl_acc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, HALTED} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_NAD = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_JMP = 4'h7,
    OP_JZ  = 4'h8, OP_JNZ = 4'h9, OP_HLT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic arg;
    logic nad;
    logic shl;
    logic shr;
    logic rd;
    logic wr;
    logic acc;
  } strobe_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [3:0]        op_q;
  logic              zflag;
  logic              op_illegal;
  strobe_t           strb_d, strb_q;

  assign op_illegal = (op_q >= 4'hA) && (op_q <= 4'hE);

  // Decode straight from ROM data; only registered in LOAD so strobes live in EXEC alone.
  always_comb begin
    strb_d = '0;
    case (prog_data[19:16])
      OP_LDI: begin strb_d.arg = 1'b1; strb_d.acc = 1'b1; end
      OP_LD:  begin strb_d.rd  = 1'b1; strb_d.acc = 1'b1; end
      OP_ST:  strb_d.wr = 1'b1;
      OP_NAD: begin strb_d.nad = 1'b1; strb_d.rd = 1'b1; strb_d.acc = 1'b1; end
      OP_SHL: begin strb_d.shl = 1'b1; strb_d.acc = 1'b1; end
      OP_SHR: begin strb_d.shr = 1'b1; strb_d.acc = 1'b1; end
      default: strb_d = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nx = FETCH;
          pc_nx    = PC_INIT;
        end
      end
      FETCH: state_nx = LOAD;
      LOAD:  state_nx = EXEC;
      EXEC: begin
        state_nx = FETCH;
        pc_nx    = pc + 1'b1;
        case (op_q)
          OP_JMP: pc_nx = arg[ADDR_W-1:0];
          OP_JZ:  if (zflag)  pc_nx = arg[ADDR_W-1:0];
          OP_JNZ: if (!zflag) pc_nx = arg[ADDR_W-1:0];
          OP_HLT: begin state_nx = HALTED; pc_nx = pc; end
          default: begin
            if (op_illegal) begin
              state_nx = HALTED;
              pc_nx    = pc;
            end
          end
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= PC_INIT;
      op_q    <= '0;
      arg     <= '0;
      strb_q  <= '0;
      zflag   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      strb_q <= '0;
      if ((state == IDLE || state == HALTED) && start) begin
        zflag   <= 1'b0;
        illegal <= 1'b0;
      end
      if (state == LOAD) begin
        op_q   <= prog_data[19:16];
        arg    <= prog_data[15:0];
        strb_q <= strb_d;
      end
      if (state == EXEC) begin
        if (strb_q.acc) zflag   <= is_zero;
        if (op_illegal) illegal <= 1'b1;
      end
    end
  end

  assign prog_addr = pc;
  assign ctl_arg   = strb_q.arg;
  assign ctl_nad   = strb_q.nad;
  assign ctl_shl   = strb_q.shl;
  assign ctl_shr   = strb_q.shr;
  assign ctl_read  = strb_q.rd;
  assign ctl_write = strb_q.wr;
  assign ctl_acc   = strb_q.acc;
  assign busy      = (state == FETCH) || (state == LOAD) || (state == EXEC);
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ISA-level reference model plus a small accumulator
// datapath around the DUT, and a second 2-bit-address instance for PC wrap.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prog_addr;
  logic [19:0] prog_data = '0;
  logic [15:0] arg;
  logic        is_zero;
  logic        ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc;
  logic        busy, halted, illegal;

  logic        rst2_n = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  prog_addr2;
  logic [19:0] prog_data2 = '0;
  logic [15:0] arg2;
  logic        is_zero2 = 1'b0;
  logic        c2_arg, c2_nad, c2_shl, c2_shr, c2_read, c2_write, c2_acc;
  logic        busy2, halted2, illegal2;

  always #5 clk = ~clk;

  control_unit #(.ADDR_W(8), .RESET_PC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
    .arg(arg), .is_zero(is_zero), .ctl_arg(ctl_arg), .ctl_nad(ctl_nad), .ctl_shl(ctl_shl),
    .ctl_shr(ctl_shr), .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_acc(ctl_acc),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  control_unit #(.ADDR_W(2), .RESET_PC(0)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .start(start2), .prog_addr(prog_addr2), .prog_data(prog_data2),
    .arg(arg2), .is_zero(is_zero2), .ctl_arg(c2_arg), .ctl_nad(c2_nad), .ctl_shl(c2_shl),
    .ctl_shr(c2_shr), .ctl_read(c2_read), .ctl_write(c2_write), .ctl_acc(c2_acc),
    .busy(busy2), .halted(halted2), .illegal(illegal2)
  );

  // Synchronous program ROMs
  logic [19:0] rom [256];
  logic [19:0] rom2 [4];
  always @(posedge clk) prog_data  <= rom[prog_addr];
  always @(posedge clk) prog_data2 <= rom2[prog_addr2];

  // Datapath stand-in driven by the DUT strobes; is_zero reflects this cycle's result
  logic [15:0] d_acc = '0;
  logic [15:0] d_res;
  logic [15:0] dmem [256] = '{default: '0};
  always_comb begin
    d_res = d_acc;
    if (ctl_arg)       d_res = arg;
    else if (ctl_nad)  d_res = ~(d_acc & dmem[arg[7:0]]);
    else if (ctl_read) d_res = dmem[arg[7:0]];
    else if (ctl_shl)  d_res = d_acc << 1;
    else if (ctl_shr)  d_res = d_acc >> 1;
  end
  assign is_zero = (d_res == 16'h0);
  always @(posedge clk) begin
    if (ctl_acc)   d_acc <= d_res;
    if (ctl_write) dmem[arg[7:0]] <= d_acc;
  end

  // Reference model: mode 0 idle / 1 running / 2 halted, phase = cycle within instruction
  int          m_mode;
  int          m_phase;
  logic [7:0]  m_pc;
  logic [15:0] m_arg;
  logic [15:0] m_acc = '0;
  logic [15:0] m_mem [256] = '{default: '0};
  logic        m_z, m_ill;
  logic [3:0]  m_op;
  logic [15:0] m_res;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] acc,
                                      input logic [15:0] opnd, input logic [15:0] mval);
    case (op)
      4'h1:    return opnd;
      4'h2:    return mval;
      4'h4:    return ~(acc & mval);
      4'h5:    return acc << 1;
      4'h6:    return acc >> 1;
      default: return acc;
    endcase
  endfunction

  assign m_op  = rom[m_pc][19:16];
  assign m_res = alu(m_op, m_acc, m_arg, m_mem[m_arg[7:0]]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_phase <= 0; m_pc <= 8'd0; m_arg <= '0; m_z <= 1'b0; m_ill <= 1'b0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode <= 1; m_phase <= 0; m_pc <= 8'd0; m_z <= 1'b0; m_ill <= 1'b0;
      end
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_phase <= 2;
      m_arg   <= rom[m_pc][15:0];
    end else begin
      m_phase <= 0;
      if (m_op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6}) begin
        m_acc <= m_res;
        m_z   <= (m_res == 16'h0);
      end
      if (m_op == 4'h3) m_mem[m_arg[7:0]] <= m_acc;
      case (m_op)
        4'h7:    m_pc <= m_arg[7:0];
        4'h8:    m_pc <= m_z ? m_arg[7:0] : m_pc + 8'd1;
        4'h9:    m_pc <= m_z ? m_pc + 8'd1 : m_arg[7:0];
        4'hF:    m_mode <= 2;
        4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin m_mode <= 2; m_ill <= 1'b1; end
        default: m_pc <= m_pc + 8'd1;
      endcase
    end
  end

  logic       m_exec;
  logic [6:0] e_strb, a_strb;
  assign m_exec = (m_mode == 1) && (m_phase == 2);
  assign e_strb = {m_exec && m_op == 4'h1, m_exec && m_op == 4'h4, m_exec && m_op == 4'h5,
                   m_exec && m_op == 4'h6, m_exec && m_op inside {4'h2, 4'h4},
                   m_exec && m_op == 4'h3, m_exec && m_op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6}};
  assign a_strb = {ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc};

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every bench cycle ends here: sample at negedge and compare the whole DUT output set
  task automatic tick();
    logic [31:0] act, exp;
    @(negedge clk);
    cyc++;
    act = {prog_addr, arg, a_strb, busy};
    exp = {m_pc, m_arg, e_strb, m_mode == 1};
    if (m_mode == 2) begin
      act[31:24] = 8'h0;
      exp[31:24] = 8'h0;
    end
    chk("model_outputs", act, exp);
    chk("model_status", {halted, illegal}, {m_mode == 2, m_ill});
  endtask

  int busy_cnt, strobe_cycles, n_ldi5, n_st10;
  int pcs[$];

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 20'h00000;
  endtask

  // Starts the program and runs it to HALTED; bit0 of mode pulses start mid-run,
  // bit1 raises start during the EXEC of HLT.
  task automatic run(input int mode, input int budget);
    int idx;
    busy_cnt = 0; strobe_cycles = 0; n_ldi5 = 0; n_st10 = 0; pcs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    while (busy && idx < budget) begin
      if (idx % 3 == 0) pcs.push_back(int'(prog_addr));
      busy_cnt++;
      if (|a_strb) strobe_cycles++;
      if (ctl_arg && ctl_acc && arg == 16'h0005) n_ldi5++;
      if (ctl_write && arg == 16'h0010) n_st10++;
      start = ((mode & 1) != 0 && (idx == 4 || idx == 7)) ||
              ((mode & 2) != 0 && m_exec && m_op == 4'hF);
      idx++;
      tick();
    end
    start = 1'b0;
    if (idx >= budget) chk("run_timeout", 32'(idx), 32'(budget - 1));
  endtask

  int exp_loop[5] = '{0, 1, 3, 4, 6};
  int exp_ign[5]  = '{0, 1, 2, 4, 5};

  initial begin
    int n;
    clear_rom();
    for (int i = 0; i < 4; i++) rom2[i] = 20'h00000;
    rom2[3] = 20'h70000;

    // Reset state
    tick(); tick();
    chk("rst_prog_addr", 32'(prog_addr), 32'h0);
    chk("rst_arg", 32'(arg), 32'h0);
    chk("rst_flags", {a_strb, busy, halted, illegal}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // LDI 5; ST 0x10; HLT
    rom[0] = 20'h10005; rom[1] = 20'h30010; rom[2] = 20'hF0000;
    run(0, 60);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t1_ldi_pulse", 32'(n_ldi5), 32'd1);
    chk("t1_st_pulse", 32'(n_st10), 32'd1);
    chk("t1_halted_illegal", {halted, illegal}, 32'b10);
    chk("t1_mem_0x10", 32'(dmem[8'h10]), 32'h5);

    // Conditional-jump loop
    clear_rom();
    rom[0] = 20'h10000; rom[1] = 20'h80003; rom[2] = 20'hF0000; rom[3] = 20'h10001;
    rom[4] = 20'h90006; rom[5] = 20'hF0000; rom[6] = 20'hF0000;
    run(0, 60);
    chk("t2_npcs", 32'(pcs.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t2_pc_seq", (i < pcs.size()) ? 32'(pcs[i]) : 32'hFFFF_FFFF, 32'(exp_loop[i]));
    chk("t2_strobe_cycles", 32'(strobe_cycles), 32'd2);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd15);

    // Illegal opcode, then restart
    clear_rom();
    rom[0] = 20'hB1234;
    run(0, 60);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("t3_strobe_cycles", 32'(strobe_cycles), 32'd0);
    chk("t3_halted_illegal", {halted, illegal}, 32'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_restart", {busy, halted, illegal, prog_addr}, {3'b100, 8'h00});
    tick(); tick(); tick();
    chk("t3_rehalt", {halted, illegal}, 32'b11);

    // Reset during EXEC of ST aborts the write
    clear_rom();
    rom[0] = 20'h10007; rom[1] = 20'h30030; rom[2] = 20'hF0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_exec && m_op == 4'h3) && n < 20) begin tick(); n++; end
    chk("t4_reach_st", 32'(n < 20), 32'h1);
    chk("t4_write_high", {ctl_write, arg}, {1'b1, 16'h0030});
    #2 rst_n = 1'b0;
    #1;
    chk("t4_write_dropped", 32'(ctl_write), 32'h0);
    chk("t4_idle_after_rst", {busy, halted, arg, prog_addr}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_mem_untouched", 32'(dmem[8'h30]), 32'h0);

    // start while busy and during EXEC of HLT is ignored
    clear_rom();
    rom[0] = 20'h10003; rom[1] = 20'h50000; rom[2] = 20'h90004; rom[3] = 20'hF0000;
    rom[4] = 20'h40020; rom[5] = 20'hF0000;
    run(3, 60);
    chk("t5_npcs", 32'(pcs.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t5_pc_seq", (i < pcs.size()) ? 32'(pcs[i]) : 32'hFFFF_FFFF, 32'(exp_ign[i]));
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd15);
    chk("t5_halted_after", {busy, halted}, 32'b01);
    tick();
    chk("t5_still_halted", {busy, halted}, 32'b01);

    // PC wrap with 2-bit addresses
    rst2_n = 1'b1;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("t6_wrap", {busy2, halted2, c2_arg, c2_nad, c2_shl, c2_shr, c2_read, c2_write, c2_acc, prog_addr2},
          {9'b100000000, 2'((k / 3) % 4)});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
